uart_loopback_fifo: RTL and testbench

UART_LOOPBACK_FIFO -- requirements
Module: uart_loopback_fifo

---
 rtl/uart_loopback_fifo.sv | 181 ++++++++++++++++++
 tb/tb_uart_loopback_fifo.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_fifo.sv
// uart_loopback_fifo: echoes received UART characters back to the
// transmitter through a FIFO, with rts/cts flow control.
//
// Ports:
//   sys_clk, sys_rst_n   clock, async active-low reset
//   rx_data, rx_valid    character strobe from the UART receiver
//   tx_data, tx_start    character and one-cycle request to transmitter
//   tx_busy              transmitter is serialising a character
//   rts                  host ready to accept our transmission
//   cts                  we are ready to receive (water-mark hysteresis)
//   fill                 FIFO occupancy
//   overflow             sticky: a character was dropped
//   leds                 {cts, rts, overflow, fifo-not-empty}
//
// Optional macro UART_LOOPBACK_STATS_EN adds rx_count, tx_count
// (16-bit, wrapping) and drop_count (8-bit, saturating).

module uart_loopback_fifo #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 16,
   parameter int HIGH_WATER = 12,
   parameter int LOW_WATER  = 4
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic [DATA_W-1:0]      rx_data,
   input  logic                   rx_valid,
   output logic [DATA_W-1:0]      tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   input  logic                   rts,
   output logic                   cts,
   output logic [$clog2(DEPTH):0] fill,
   output logic                   overflow,
   output logic [3:0]             leds
`ifdef UART_LOOPBACK_STATS_EN
   ,
   output logic [15:0]            rx_count,
   output logic [15:0]            tx_count,
   output logic [7:0]             drop_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;

   localparam logic [FW-1:0] FULL = FW'(DEPTH);
   localparam logic [FW-1:0] HI   = FW'(HIGH_WATER);
   localparam logic [FW-1:0] LO   = FW'(LOW_WATER);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [1:0]        tmo;
   logic              push;
   logic              pop;
   logic              drop;

   // The only reader is the TX FSM, which pops while in LOAD.
   // A full FIFO still accepts a character in that same cycle.
   assign pop  = (state == LOAD);
   assign push = rx_valid && ((fill != FULL) || pop);
   assign drop = rx_valid && !push;

   assign leds = {cts, rts, overflow, fill != '0};

   always_ff @(posedge sys_clk) begin
      if (push)
         mem[wptr] <= rx_data;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wptr <= '0;
         rptr <= '0;
         fill <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         unique case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // cts hysteresis: between the water marks it keeps its value.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         overflow <= 1'b0;
         cts      <= 1'b1;
      end else begin
         if (drop)
            overflow <= 1'b1;
         if (fill >= HI)
            cts <= 1'b0;
         else if (fill <= LO)
            cts <= 1'b1;
      end
   end

   // tmo counts cycles spent in WAIT_BUSY for the lost-start timeout.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= IDLE;
         tmo     <= 2'd0;
         tx_data <= '0;
      end else begin
         state <= state_nx;
         if (state == WAIT_BUSY)
            tmo <= tmo + 1'b1;
         else
            tmo <= 2'd0;
         if (pop)
            tx_data <= mem[rptr];
      end
   end

   always_comb begin
      state_nx = state;
      tx_start = 1'b0;
      unique case (state)
         IDLE: begin
            if ((fill != '0) && rts && !tx_busy)
               state_nx = LOAD;
         end
         LOAD: begin
            state_nx = START;
         end
         START: begin
            tx_start = 1'b1;
            state_nx = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy)
               state_nx = WAIT_DONE;
            else if (tmo == 2'd3)
               state_nx = IDLE;
         end
         WAIT_DONE: begin
            if (!tx_busy)
               state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

`ifdef UART_LOOPBACK_STATS_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_count   <= '0;
         tx_count   <= '0;
         drop_count <= '0;
      end else begin
         if (push)
            rx_count <= rx_count + 1'b1;
         if (tx_start)
            tx_count <= tx_count + 1'b1;
         if (drop && (drop_count != 8'hFF))
            drop_count <= drop_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// tb_uart_loopback_fifo: scoreboard bench for uart_loopback_fifo.
// Expected characters are queued at rx time and checked at tx_start.

module tb_uart_loopback_fifo;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b1;
   logic [7:0] rx_data   = 8'h00;
   logic       rx_valid  = 1'b0;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       rts       = 1'b0;
   logic       cts;
   logic [4:0] fill;
   logic       overflow;
   logic [3:0] leds;
`ifdef UART_LOOPBACK_STATS_EN
   logic [15:0] rx_count;
   logic [15:0] tx_count;
   logic [7:0]  drop_count;
`endif

   int vecs    = 0;
   int misses  = 0;
   int tx_seen = 0;

   logic [7:0] sbq [$];

   // Transmitter model: busy for busy_len cycles after each tx_start.
   bit   model_en   = 1'b1;
   logic busy_force = 1'b0;
   int   busy_len   = 3;
   int   busy_cnt;

   assign tx_busy = model_en ? (busy_cnt != 0) : busy_force;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         busy_cnt <= 0;
      else if (tx_start)
         busy_cnt <= busy_len;
      else if (busy_cnt != 0)
         busy_cnt <= busy_cnt - 1;
   end

   always #5 sys_clk = ~sys_clk;

   uart_loopback_fifo dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .rts        (rts),
      .cts        (cts),
      .fill       (fill),
      .overflow   (overflow),
      .leds       (leds)
`ifdef UART_LOOPBACK_STATS_EN
      ,
      .rx_count   (rx_count),
      .tx_count   (tx_count),
      .drop_count (drop_count)
`endif
   );

   // Scoreboard consumer: every tx_start must carry the oldest
   // outstanding character.
   always @(negedge sys_clk) begin
      if (sys_rst_n && tx_start) begin
         tx_seen++;
         vecs++;
         if (sbq.size() == 0) begin
            misses++;
            $display("FAIL tx_unexpected got %0h want none", tx_data);
         end else begin
            logic [7:0] exp;
            exp = sbq.pop_front();
            if (tx_data !== exp) begin
               misses++;
               $display("FAIL tx_order got %0h want %0h",
                        tx_data, exp);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      sbq.delete();
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string nm);
      for (int c = 0; c < 600; c++) begin
         if (sbq.size() == 0 && fill == 5'd0 && !tx_busy)
            break;
         tick();
      end
      repeat (8) tick();
      vecs++;
      if (sbq.size() != 0 || fill !== 5'd0) begin
         misses++;
         $display("FAIL %s_drain got q=%0d fill=%0d want 0 0",
                  nm, sbq.size(), fill);
      end
   endtask

   task automatic test_reset();
      rts      = 1'b0;
      rx_valid = 1'b0;
      #2 sys_rst_n = 1'b0;
      #1;
      vecs++;
      if ({fill, cts, tx_start, tx_data, overflow}
          !== {5'd0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
         misses++;
         $display("FAIL rst_vals got f=%0d c=%b s=%b d=%0h o=%b want 0 1 0 0 0",
                  fill, cts, tx_start, tx_data, overflow);
      end
      vecs++;
      if (leds !== 4'b1000) begin
         misses++;
         $display("FAIL rst_leds got %b want 1000", leds);
      end
`ifdef UART_LOOPBACK_STATS_EN
      vecs++;
      if ({rx_count, tx_count, drop_count} !== 40'd0) begin
         misses++;
         $display("FAIL rst_stats got %0d %0d %0d want 0 0 0",
                  rx_count, tx_count, drop_count);
      end
`endif
      // release with rx_valid already high: first edge must push
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      rx_data   = 8'h11;
      rx_valid  = 1'b1;
      tick();
      rx_valid = 1'b0;
      vecs++;
      if (fill !== 5'd1) begin
         misses++;
         $display("FAIL rst_first_push got %0d want 1", fill);
      end
      // asynchronous assertion between edges
      #2 sys_rst_n = 1'b0;
      #1;
      vecs++;
      if (fill !== 5'd0 || leds !== 4'b1000) begin
         misses++;
         $display("FAIL rst_async got f=%0d l=%b want 0 1000",
                  fill, leds);
      end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   task automatic test_single();
      int t0;
      do_reset();
      rts      = 1'b1;
      model_en = 1'b1;
      tick();
      t0 = tx_seen;
      rx_data  = 8'h41;
      rx_valid = 1'b1;
      sbq.push_back(8'h41);
      tick();
      rx_valid = 1'b0;
      vecs++;
      if (fill !== 5'd1 || tx_start !== 1'b0) begin
         misses++;
         $display("FAIL single_c1 got f=%0d s=%b want 1 0",
                  fill, tx_start);
      end
      tick();
      vecs++;
      if (tx_start !== 1'b0) begin
         misses++;
         $display("FAIL single_c2 got %b want 0", tx_start);
      end
      tick();
      vecs++;
      if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
         misses++;
         $display("FAIL single_latency got s=%b d=%0h want 1 41",
                  tx_start, tx_data);
      end
      wait_drain("single");
      vecs++;
      if (tx_seen - t0 != 1) begin
         misses++;
         $display("FAIL single_count got %0d want 1", tx_seen - t0);
      end
   endtask

   task automatic test_burst();
      int  t0;
      int  ef;
      bit  low_seen;
      bit  cts_done;
      do_reset();
      rts = 1'b0;
      tick();
      t0 = tx_seen;
      for (int i = 0; i < 20; i++) begin
         rx_data  = 8'(i);
         rx_valid = 1'b1;
         if (i < 16)
            sbq.push_back(8'(i));
         tick();
         ef = (i < 16) ? i + 1 : 16;
         vecs++;
         if (fill !== 5'(ef)) begin
            misses++;
            $display("FAIL burst_fill got %0d want %0d", fill, ef);
         end
         if (i == 11 || i == 12) begin
            vecs++;
            if (cts !== (i == 11)) begin
               misses++;
               $display("FAIL burst_cts_fall got %b want %b",
                        cts, i == 11);
            end
         end
         if (i == 15 || i == 16) begin
            vecs++;
            if (overflow !== (i == 16)) begin
               misses++;
               $display("FAIL burst_ovf got %b want %b",
                        overflow, i == 16);
            end
         end
      end
      rx_valid = 1'b0;
      vecs++;
      if (leds !== 4'b0011) begin
         misses++;
         $display("FAIL burst_leds got %b want 0011", leds);
      end
      rts      = 1'b1;
      low_seen = 1'b0;
      cts_done = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (sbq.size() == 0 && fill == 5'd0 && cts_done)
            break;
         tick();
         if (low_seen && !cts_done) begin
            cts_done = 1'b1;
            vecs++;
            if (cts !== 1'b1) begin
               misses++;
               $display("FAIL burst_cts_rise got %b want 1", cts);
            end
         end else if (!low_seen && fill > 5'd4) begin
            vecs++;
            if (cts !== 1'b0) begin
               misses++;
               $display("FAIL burst_cts_hold got %b want 0", cts);
            end
         end
         if (fill <= 5'd4)
            low_seen = 1'b1;
      end
      wait_drain("burst");
      vecs++;
      if (tx_seen - t0 != 16 || overflow !== 1'b1) begin
         misses++;
         $display("FAIL burst_total got n=%0d o=%b want 16 1",
                  tx_seen - t0, overflow);
      end
`ifdef UART_LOOPBACK_STATS_EN
      vecs++;
      if (rx_count !== 16'd16 || tx_count !== 16'd16
          || drop_count !== 8'd4) begin
         misses++;
         $display("FAIL burst_stats got %0d %0d %0d want 16 16 4",
                  rx_count, tx_count, drop_count);
      end
`endif
   endtask

   task automatic test_full_pop();
      do_reset();
      rts = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         rx_data  = 8'h80 + 8'(i);
         rx_valid = 1'b1;
         sbq.push_back(8'h80 + 8'(i));
         tick();
      end
      rx_valid = 1'b0;
      vecs++;
      if (fill !== 5'd16 || overflow !== 1'b0) begin
         misses++;
         $display("FAIL full_pre got f=%0d o=%b want 16 0",
                  fill, overflow);
      end
      rts = 1'b1;
      tick();
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      sbq.push_back(8'hA5);
      tick();
      rx_valid = 1'b0;
      vecs++;
      if (fill !== 5'd16 || overflow !== 1'b0 || tx_start !== 1'b1) begin
         misses++;
         $display("FAIL full_pop got f=%0d o=%b s=%b want 16 0 1",
                  fill, overflow, tx_start);
      end
      wait_drain("full");
      vecs++;
      if (overflow !== 1'b0) begin
         misses++;
         $display("FAIL full_ovf got %b want 0", overflow);
      end
   endtask

   task automatic test_lost_start();
      int t0;
      int gap;
      do_reset();
      rts        = 1'b1;
      model_en   = 1'b0;
      busy_force = 1'b0;
      tick();
      t0 = tx_seen;
      rx_data  = 8'h3C;
      rx_valid = 1'b1;
      sbq.push_back(8'h3C);
      tick();
      rx_data = 8'h7E;
      sbq.push_back(8'h7E);
      tick();
      rx_valid = 1'b0;
      tick();
      vecs++;
      if (tx_start !== 1'b1) begin
         misses++;
         $display("FAIL lost_first got %b want 1", tx_start);
      end
      gap = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (tx_start) begin
            gap = k;
            break;
         end
      end
      vecs++;
      if (gap != 7) begin
         misses++;
         $display("FAIL lost_timeout got %0d want 7", gap);
      end
      repeat (20) tick();
      vecs++;
      if (tx_seen - t0 != 2 || fill !== 5'd0) begin
         misses++;
         $display("FAIL lost_resend got n=%0d f=%0d want 2 0",
                  tx_seen - t0, fill);
      end
      model_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      rts      = 1'b0;
      model_en = 1'b1;
      busy_len = 20;
      tick();
      for (int i = 0; i < 6; i++) begin
         rx_data  = 8'h60 + 8'(i);
         rx_valid = 1'b1;
         sbq.push_back(8'h60 + 8'(i));
         tick();
      end
      rx_valid = 1'b0;
      rts = 1'b1;
      repeat (5) tick();
      vecs++;
      if (fill !== 5'd5 || tx_busy !== 1'b1) begin
         misses++;
         $display("FAIL mid_pre got f=%0d b=%b want 5 1",
                  fill, tx_busy);
      end
      #2 sys_rst_n = 1'b0;
      #1;
      vecs++;
      if ({fill, cts, tx_start, tx_data}
          !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
         misses++;
         $display("FAIL mid_async got f=%0d c=%b s=%b d=%0h want 0 1 0 0",
                  fill, cts, tx_start, tx_data);
      end
      sbq.delete();
      busy_len = 3;
      rx_data  = 8'h55;
      rx_valid = 1'b1;
      sbq.push_back(8'h55);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      tick();
      rx_valid = 1'b0;
      vecs++;
      if (fill !== 5'd1) begin
         misses++;
         $display("FAIL mid_first_edge got %0d want 1", fill);
      end
      tick();
      tick();
      vecs++;
      if (tx_start !== 1'b1 || tx_data !== 8'h55) begin
         misses++;
         $display("FAIL mid_echo got s=%b d=%0h want 1 55",
                  tx_start, tx_data);
      end
      wait_drain("mid");
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_full_pop();
      test_lost_start();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==",
               vecs, misses);
      $finish;
   end

endmodule
